// File: rtl/pipe_regfile_decode.sv
// Register-file decode stage: resolves Y86-style source operands, reads a
// two-write-port register file and holds one decoded result behind a valid/ready handshake.

module prd_operand #(
    parameter int XLEN   = 64,
    parameter int NREG   = 15,
    parameter int BYPASS = 1
) (
    input  logic [NREG-1:0][XLEN-1:0] i_regs,
    input  logic [3:0]                i_src,
    input  logic                      i_wE_en,
    input  logic [3:0]                i_dstE,
    input  logic [XLEN-1:0]           i_valE,
    input  logic                      i_wM_en,
    input  logic [3:0]                i_dstM,
    input  logic [XLEN-1:0]           i_valM,
    output logic [XLEN-1:0]           o_val
);
    localparam logic [3:0] NREG4 = 4'(NREG);

    logic [XLEN-1:0] w_rd;
    logic            w_src_ok;

    // Indices outside the file (including RNONE) read as zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_src == 4'(i)) w_rd = i_regs[i];
        end
    end

    assign w_src_ok = (i_src < NREG4);

    always_comb begin
        o_val = w_rd;
        if (BYPASS != 0 && w_src_ok) begin
            if (i_wM_en && i_dstM == i_src)      o_val = i_valM;
            else if (i_wE_en && i_dstE == i_src) o_val = i_valE;
        end
    end
endmodule

module pipe_regfile_decode #(
    parameter int XLEN    = 64,
    parameter int NREG    = 15,
    parameter int RSP_IDX = 4,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      icode,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [3:0]      out_icode,
    output logic [3:0]      srcA,
    output logic [3:0]      srcB,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    input  logic            wE_en,
    input  logic            wM_en,
    input  logic [3:0]      dstE,
    input  logic [3:0]      dstM,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valM
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_IDX);

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [1:0][3:0]           w_src;
    logic [1:0][XLEN-1:0]      w_val;
    logic                      w_capture;

    logic            r_out_valid;
    logic [3:0]      r_out_icode;
    logic [1:0][3:0] r_src;
    logic [1:0][XLEN-1:0] r_val;

    always_comb begin
        w_src[0] = RNONE;
        w_src[1] = RNONE;
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_src[0] = rA;
            4'h9, 4'hB:             w_src[0] = RSP;
            default:                w_src[0] = RNONE;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6:       w_src[1] = rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_src[1] = RSP;
            default:                w_src[1] = RNONE;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_opnd
            prd_operand #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_opnd (
                .i_regs (r_regs),
                .i_src  (w_src[g]),
                .i_wE_en(wE_en),
                .i_dstE (dstE),
                .i_valE (valE),
                .i_wM_en(wM_en),
                .i_dstM (dstM),
                .i_valM (valM),
                .o_val  (w_val[g])
            );
        end
    endgenerate

    // Writes ignore the handshake entirely; port M takes priority on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= XLEN'(i + 1);
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wM_en && dstM == 4'(i))      r_regs[i] <= valM;
                else if (wE_en && dstE == 4'(i)) r_regs[i] <= valE;
            end
        end
    end

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    // Flush only drops valid; the held payload is left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_icode <= 4'h0;
            r_src       <= {RNONE, RNONE};
            r_val       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_icode <= icode;
            r_src       <= w_src;
            r_val       <= w_val;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_icode = r_out_icode;
    assign srcA      = r_src[0];
    assign srcB      = r_src[1];
    assign valA      = r_val[0];
    assign valB      = r_val[1];
endmodule
